c2v_serial_expand: RTL

Serial check-to-variable (C2V) message expander for the check node unit (CNU) datapath. It accepts one compressed check-node record per handshake: minimum magnitude, second-minimum magnitude, argmin edge index, and per-edge V2C sign bits. It then emits CN_DEGREE per-edge C2V messages, one per cycle, in edge order. It sits between the min-finder tree output and the variable-node message memory write port, and is the expanding counterpart of the compressing min-finder.

---
 rtl/c2v_serial_expand_pkg.sv | 17 +
 rtl/c2v_rec_buf.sv | 37 +++
 rtl/c2v_serial_expand.sv | 79 +++++++
 3 files changed

// File: rtl/c2v_serial_expand_pkg.sv
// c2v_serial_expand_pkg: shared constants, record type and FSM encoding for the C2V expander
package c2v_serial_expand_pkg;
  localparam int CN_DEGREE_DEF = 10;
  localparam int QUAN_SIZE_DEF = 3;
  function automatic int idx_width(input int deg);
    return (deg <= 2) ? 1 : $clog2(deg);
  endfunction
  localparam int IDX_WIDTH_DEF = idx_width(CN_DEGREE_DEF);
  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;
  typedef struct packed {
    logic [QUAN_SIZE_DEF-1:0] m1;
    logic [QUAN_SIZE_DEF-1:0] m2;
    logic [IDX_WIDTH_DEF-1:0] min_index;
    logic [CN_DEGREE_DEF-1:0] signs;
    logic                     sign_prod;
  } rec_t;
endpackage

// File: rtl/c2v_rec_buf.sv
// c2v_rec_buf: two-slot (active/pending) record buffer with load and move logic
module c2v_rec_buf
  import c2v_serial_expand_pkg::*;
(
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_valid,
  input  logic i_act_valid,
  input  logic i_done,
  input  rec_t i_rec,
  output logic o_ready,
  output rec_t o_act
);
  logic r_pend_valid;
  rec_t r_act;
  rec_t r_pend;
  logic w_accept;
  logic w_to_act;
  logic w_to_pend;
  assign w_accept  = i_valid & ~r_pend_valid;
  assign w_to_act  = w_accept & (~i_act_valid | i_done);
  assign w_to_pend = w_accept & i_act_valid & ~i_done;
  assign o_ready   = ~r_pend_valid;
  assign o_act     = r_act;
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_pend_valid <= 1'b0;
      r_act        <= '0;
      r_pend       <= '0;
    end else begin
      r_pend_valid <= w_to_pend | (r_pend_valid & ~i_done);
      if (w_to_act) r_act <= i_rec;
      else if (i_done & r_pend_valid) r_act <= r_pend;
      if (w_to_pend) r_pend <= i_rec;
    end
  end
endmodule

// File: rtl/c2v_serial_expand.sv
// c2v_serial_expand: expands a compressed check-node record into CN_DEGREE serial C2V beats
module c2v_serial_expand
  import c2v_serial_expand_pkg::*;
#(
  parameter int QUAN_SIZE = QUAN_SIZE_DEF,
  parameter int CN_DEGREE = CN_DEGREE_DEF,
  parameter int IDX_WIDTH = IDX_WIDTH_DEF
) (
  input  logic                 sys_clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [QUAN_SIZE-1:0] in_m1,
  input  logic [QUAN_SIZE-1:0] in_m2,
  input  logic [IDX_WIDTH-1:0] in_min_index,
  input  logic [CN_DEGREE-1:0] in_signs,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [QUAN_SIZE-1:0] out_mag,
  output logic                 out_sign,
  output logic [IDX_WIDTH-1:0] out_edge,
  output logic                 out_last
);
  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDX_WIDTH-1:0] r_edge_cnt;
  rec_t                 w_rec;
  rec_t                 w_act;
  logic                 w_emit;
  logic                 w_accept;
  logic                 w_hs;
  logic                 w_last;
  logic                 w_done;
  logic                 w_hit;
  assign w_rec = '{
    m1:        QUAN_SIZE_DEF'(in_m1),
    m2:        QUAN_SIZE_DEF'(in_m2),
    min_index: IDX_WIDTH_DEF'(in_min_index),
    signs:     CN_DEGREE_DEF'(in_signs),
    sign_prod: ^in_signs
  };
  c2v_rec_buf u_buf (
    .i_clk      (sys_clk),
    .i_rstn     (rstn),
    .i_valid    (in_valid),
    .i_act_valid(w_emit),
    .i_done     (w_done),
    .i_rec      (w_rec),
    .o_ready    (in_ready),
    .o_act      (w_act)
  );
  assign w_emit   = r_state == EMIT;
  assign w_accept = in_valid & in_ready;
  assign w_hs     = w_emit & out_ready;
  assign w_last   = r_edge_cnt == IDX_WIDTH'(CN_DEGREE - 1);
  assign w_done   = w_hs & w_last;
  assign w_hit    = r_edge_cnt == IDX_WIDTH'(w_act.min_index);
  // in_ready high on the last beat means no pending record can refill ACTIVE
  always_comb begin
    w_state_nxt = (r_state == IDLE) ? (w_accept ? EMIT : IDLE)
                                    : ((w_done & in_ready & ~w_accept) ? IDLE : EMIT);
  end
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_edge_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hs) r_edge_cnt <= w_last ? '0 : r_edge_cnt + 1'b1;
    end
  end
  always_comb begin
    out_valid = w_emit;
    out_mag   = w_emit ? QUAN_SIZE'(w_hit ? w_act.m2 : w_act.m1) : '0;
    out_sign  = w_emit & (w_act.sign_prod ^ w_act.signs[r_edge_cnt]);
    out_edge  = w_emit ? r_edge_cnt : '0;
    out_last  = w_emit & w_last;
  end
endmodule
